// File: rtl/binop_scheduler.sv
// binop_scheduler
// Round-robin scheduler that shares one binary-operation datapath among
// REQ_CNT requesters. Bitwise, add/sub and signed compares complete in one
// cycle. Shifts run one bit per cycle in the result register. Each result is
// held behind a valid/ready handshake and is tagged with the requester id.
//
// Ports
//   clk, rst_n      clock and asynchronous active-low reset
//   req_valid/ready per-requester handshake (req_ready is a one-hot grant)
//   req_op/a/b      packed per-requester opcode and operands (slice i = req i)
//   rsp_valid/ready result handshake
//   rsp_data        DATA_W+1 bit result
//   rsp_id          index of the requester that owns the result
//   rsp_err         set when the opcode was illegal
//
// state  | meaning
// IDLE   | output empty; grant the round-robin winner
// SHIFT  | result register shifts 1 bit/cycle while cnt counts down
// RESP   | rsp_valid=1; result held until rsp_ready

module binop_scheduler #(
    parameter int REQ_CNT = 4,
    parameter int DATA_W  = 4,
    parameter int ID_W    = $clog2(REQ_CNT)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REQ_CNT-1:0]        req_valid,
    output logic [REQ_CNT-1:0]        req_ready,
    input  logic [4*REQ_CNT-1:0]      req_op,
    input  logic [DATA_W*REQ_CNT-1:0] req_a,
    input  logic [DATA_W*REQ_CNT-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W:0]           rsp_data,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      rsp_err
);

    localparam int RW     = DATA_W + 1;
    localparam int MAX_SH = DATA_W + 1;
    localparam int CNT_W  = $clog2(MAX_SH + 1);

    localparam logic [3:0] OP_AND = 4'd0,  OP_OR  = 4'd1,  OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3,  OP_LT  = 4'd4,  OP_LE  = 4'd5;
    localparam logic [3:0] OP_EQ  = 4'd6,  OP_NE  = 4'd7,  OP_GT  = 4'd8;
    localparam logic [3:0] OP_GE  = 4'd9,  OP_SHL = 4'd10, OP_SHR = 4'd11;
    localparam logic [3:0] OP_SAR = 4'd12;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_RESP} state_t;

    state_t state, state_nxt;

    logic [ID_W-1:0]   last;
    logic [CNT_W-1:0]  cnt;
    logic [3:0]        cur_op;

    logic              gnt_found;
    logic [ID_W-1:0]   gnt_idx;
    int                gnt_int;
    logic              can_accept;
    logic              accept;

    logic [3:0]        sel_op;
    logic [DATA_W-1:0] sel_a, sel_b;
    logic [RW-1:0]     ext_a, ext_b;
    logic [RW-1:0]     new_data;
    logic              new_err;
    logic              new_shift;
    logic [CNT_W-1:0]  sh_amt;

    // Round-robin search starting one past the last granted requester.
    always_comb begin : arb
        int idx;
        gnt_found = 1'b0;
        gnt_int   = 0;
        idx       = 0;
        for (int k = 1; k <= REQ_CNT; k++) begin
            idx = (int'(last) + k) % REQ_CNT;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_int   = idx;
            end
        end
        gnt_idx = ID_W'(gnt_int);
    end

    assign sel_op = req_op[gnt_int*4 +: 4];
    assign sel_a  = req_a[gnt_int*DATA_W +: DATA_W];
    assign sel_b  = req_b[gnt_int*DATA_W +: DATA_W];
    assign ext_a  = {sel_a[DATA_W-1], sel_a};
    assign ext_b  = {sel_b[DATA_W-1], sel_b};
    assign sh_amt = (int'(sel_b) > MAX_SH) ? CNT_W'(MAX_SH) : CNT_W'(sel_b);

    // For shifts new_data is the pre-shift operand; SHIFT state does the rest.
    always_comb begin
        new_data  = '0;
        new_err   = 1'b0;
        new_shift = 1'b0;
        case (sel_op)
            OP_AND: new_data = {1'b0, sel_a & sel_b};
            OP_OR:  new_data = {1'b0, sel_a | sel_b};
            OP_ADD: new_data = ext_a + ext_b;
            OP_SUB: new_data = ext_a - ext_b;
            OP_LT:  new_data = {{DATA_W{1'b0}}, $signed(sel_a) <  $signed(sel_b)};
            OP_LE:  new_data = {{DATA_W{1'b0}}, $signed(sel_a) <= $signed(sel_b)};
            OP_EQ:  new_data = {{DATA_W{1'b0}}, sel_a == sel_b};
            OP_NE:  new_data = {{DATA_W{1'b0}}, sel_a != sel_b};
            OP_GT:  new_data = {{DATA_W{1'b0}}, $signed(sel_a) >  $signed(sel_b)};
            OP_GE:  new_data = {{DATA_W{1'b0}}, $signed(sel_a) >= $signed(sel_b)};
            OP_SHL, OP_SHR: begin
                new_data  = {1'b0, sel_a};
                new_shift = 1'b1;
            end
            OP_SAR: begin
                new_data  = ext_a;
                new_shift = 1'b1;
            end
            default: new_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept)
                    state_nxt = (new_shift && sh_amt != '0) ? ST_SHIFT : ST_RESP;
            end
            ST_SHIFT: begin
                if (cnt == CNT_W'(1)) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    if (!accept)                          state_nxt = ST_IDLE;
                    else if (new_shift && sh_amt != '0)   state_nxt = ST_SHIFT;
                    else                                  state_nxt = ST_RESP;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // rst_n gates the grant so req_ready is 0 throughout reset.
    always_comb begin
        rsp_valid  = (state == ST_RESP);
        can_accept = rst_n && ((state == ST_IDLE) || (state == ST_RESP && rsp_ready));
        req_ready  = '0;
        if (can_accept && gnt_found) req_ready[gnt_int] = 1'b1;
    end

    assign accept = can_accept && gnt_found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data <= '0;
            rsp_id   <= '0;
            rsp_err  <= 1'b0;
            cnt      <= '0;
            cur_op   <= '0;
            last     <= ID_W'(REQ_CNT - 1);
        end else if (accept) begin
            rsp_data <= new_data;
            rsp_id   <= gnt_idx;
            rsp_err  <= new_err;
            cnt      <= sh_amt;
            cur_op   <= sel_op;
            last     <= gnt_idx;
        end else if (state == ST_SHIFT) begin
            case (cur_op)
                OP_SHL:  rsp_data <= {rsp_data[RW-2:0], 1'b0};
                OP_SHR:  rsp_data <= {1'b0, rsp_data[RW-1:1]};
                default: rsp_data <= {rsp_data[RW-1], rsp_data[RW-1:1]};
            endcase
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_binop_scheduler.sv
module tb_binop_scheduler;

    localparam int REQ_CNT = 4;
    localparam int DATA_W  = 4;
    localparam int ID_W    = 2;

    logic                      clk;
    logic                      rst_n;
    logic [REQ_CNT-1:0]        req_valid;
    logic [REQ_CNT-1:0]        req_ready;
    logic [4*REQ_CNT-1:0]      req_op;
    logic [DATA_W*REQ_CNT-1:0] req_a;
    logic [DATA_W*REQ_CNT-1:0] req_b;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_W:0]           rsp_data;
    logic [ID_W-1:0]           rsp_id;
    logic                      rsp_err;

    int n_cmp  = 0;
    int n_fail = 0;

    binop_scheduler #(.REQ_CNT(REQ_CNT), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] exp_data;
        logic       exp_err;
        int         lat;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] op,
                           input logic [3:0] a, input logic [3:0] b);
        req_op[i*4 +: 4]         = op;
        req_a[i*DATA_W +: DATA_W] = a;
        req_b[i*DATA_W +: DATA_W] = b;
    endtask

    initial begin
        int lat;
        bit got;

        vecs[0]  = '{4'd2,  4'h7, 4'h7, 5'h0E, 1'b0, 1};  // ADD
        vecs[1]  = '{4'd3,  4'h8, 4'h1, 5'h17, 1'b0, 1};  // SUB -8-1
        vecs[2]  = '{4'd4,  4'hF, 4'h1, 5'h01, 1'b0, 1};  // LT -1<1
        vecs[3]  = '{4'd9,  4'hF, 4'h1, 5'h00, 1'b0, 1};  // GE
        vecs[4]  = '{4'd6,  4'h5, 4'h5, 5'h01, 1'b0, 1};  // EQ
        vecs[5]  = '{4'd7,  4'h5, 4'h5, 5'h00, 1'b0, 1};  // NE
        vecs[6]  = '{4'd8,  4'h1, 4'hF, 5'h01, 1'b0, 1};  // GT 1>-1
        vecs[7]  = '{4'd5,  4'h3, 4'h3, 5'h01, 1'b0, 1};  // LE
        vecs[8]  = '{4'd0,  4'hC, 4'hA, 5'h08, 1'b0, 1};  // AND
        vecs[9]  = '{4'd1,  4'hC, 4'hA, 5'h0E, 1'b0, 1};  // OR
        vecs[10] = '{4'd2,  4'h8, 4'h8, 5'h10, 1'b0, 1};  // ADD -16
        vecs[11] = '{4'd3,  4'h7, 4'h8, 5'h0F, 1'b0, 1};  // SUB 7-(-8)
        vecs[12] = '{4'd12, 4'h8, 4'h2, 5'h1E, 1'b0, 3};  // SAR 2
        vecs[13] = '{4'd10, 4'h9, 4'h1, 5'h12, 1'b0, 2};  // SHL 1
        vecs[14] = '{4'd11, 4'h9, 4'hF, 5'h00, 1'b0, 6};  // SHR clamp 5
        vecs[15] = '{4'd12, 4'h8, 4'hF, 5'h1F, 1'b0, 6};  // SAR clamp 5
        vecs[16] = '{4'd10, 4'h9, 4'h0, 5'h09, 1'b0, 1};  // SHL 0
        vecs[17] = '{4'd11, 4'h9, 4'h1, 5'h04, 1'b0, 2};  // SHR 1
        vecs[18] = '{4'd15, 4'h7, 4'h3, 5'h00, 1'b1, 1};  // illegal
        vecs[19] = '{4'd13, 4'h9, 4'h2, 5'h00, 1'b1, 1};  // illegal

        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        // Reset state, with every requester asking.
        req_valid = 4'hF;
        #1;
        check("rst_req_ready", int'(req_ready), 0);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_rsp_data",  int'(rsp_data), 0);
        check("rst_rsp_id",    int'(rsp_id), 0);
        check("rst_rsp_err",   int'(rsp_err), 0);
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single-requester table.
        for (int v = 0; v < 20; v++) begin
            @(negedge clk);
            set_req(0, vecs[v].op, vecs[v].a, vecs[v].b);
            req_valid = 4'b0001;
            rsp_ready = 1'b0;
            #1;
            check($sformatf("v%0d_grant", v), int'(req_ready), 1);
            @(posedge clk);
            #1 req_valid = '0;
            set_req(0, 4'd0, 4'h0, 4'h0);
            lat = 1;
            got = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (rsp_valid) begin
                    got = 1;
                    break;
                end
                lat++;
            end
            check($sformatf("v%0d_got_rsp", v), int'(got), 1);
            check($sformatf("v%0d_latency", v), lat, vecs[v].lat);
            check($sformatf("v%0d_data", v), int'(rsp_data), int'(vecs[v].exp_data));
            check($sformatf("v%0d_err", v), int'(rsp_err), int'(vecs[v].exp_err));
            check($sformatf("v%0d_id", v), int'(rsp_id), 0);
            rsp_ready = 1'b1;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
        end

        // Round robin from reset: grants 0,1,2,3,0 back to back.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < REQ_CNT; i++) set_req(i, 4'd0, 4'hF, 4'(i + 1));
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("rr%0d_grant", k), int'(req_ready), 1 << (k % 4));
            if (k > 0) begin
                check($sformatf("rr%0d_valid", k), int'(rsp_valid), 1);
                check($sformatf("rr%0d_id", k), int'(rsp_id), (k - 1) % 4);
                check($sformatf("rr%0d_data", k), int'(rsp_data), ((k - 1) % 4) + 1);
            end
            @(negedge clk);
        end

        // Backpressure: fifth result (req 0) must hold, no grants.
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("bp%0d_valid", k), int'(rsp_valid), 1);
            check($sformatf("bp%0d_id", k), int'(rsp_id), 0);
            check($sformatf("bp%0d_data", k), int'(rsp_data), 1);
            check($sformatf("bp%0d_ready", k), int'(req_ready), 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_grant", int'(req_ready), 4'b0010);
        @(negedge clk);
        check("bp_next_valid", int'(rsp_valid), 1);
        check("bp_next_id", int'(rsp_id), 1);
        check("bp_next_data", int'(rsp_data), 2);
        req_valid = '0;
        @(negedge clk);
        check("bp_drained", int'(rsp_valid), 0);

        // Reset during the 3rd cycle of a SHL by 4 from requester 2.
        set_req(2, 4'd10, 4'h1, 4'h4);
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        #1;
        check("sr_grant", int'(req_ready), 4'b0100);
        @(posedge clk);
        #1 req_valid = '0;
        repeat (3) @(negedge clk);
        check("sr_shifting", int'(rsp_valid), 0);
        rst_n     = 1'b0;
        req_valid = 4'hF;
        #1;
        check("sr_rst_valid", int'(rsp_valid), 0);
        check("sr_rst_ready", int'(req_ready), 0);
        check("sr_rst_data",  int'(rsp_data), 0);
        check("sr_rst_id",    int'(rsp_id), 0);
        repeat (2) @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rsp_valid) got = 1;
        end
        check("sr_no_stale", int'(got), 0);
        for (int i = 0; i < REQ_CNT; i++) set_req(i, 4'd2, 4'h1, 4'h1);
        req_valid = 4'hF;
        #1;
        check("sr_first_grant", int'(req_ready), 1);
        @(posedge clk);
        #1 req_valid = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("sr_after_valid", int'(rsp_valid), 1);
        check("sr_after_id", int'(rsp_id), 0);
        check("sr_after_data", int'(rsp_data), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
